// File: rtl/mem_pkg.sv
// Shared definitions for the memory arbiter and its sub-blocks. The AW/DW
// defaults track the sram_ctrl CPU-side port widths.
package mem_pkg;

    localparam int AW_DEF = 20;
    localparam int DW_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

endpackage

// File: rtl/arb_prio_starve.sv
// Winner select for the two CPU ports: data has priority, but a fetch that has
// lost MAX_WAIT arbitrations in a row is forced through. Kept separate so a
// different policy or an extra requester can replace it without touching the FSM.
module arb_prio_starve
    import mem_pkg::*;
#(
    parameter int MAX_WAIT = 4
)(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   arb_en,
    input  logic   if_req,
    input  logic   d_req,
    output logic   grant,
    output owner_t winner
);

    localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

    logic [3:0] wait_cnt;

    // Combinational winner select, only meaningful while the FSM is arbitrating.
    always_comb begin
        grant  = arb_en && (if_req || d_req);
        winner = OWN_NONE;
        if (grant) begin
            winner = ((wait_cnt == MAX_W) || !d_req) ? OWN_IF : OWN_D;
        end
    end

    // Starvation counter: counts consecutive data wins while fetch is waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (!if_req) begin
            wait_cnt <= '0;
        end else if (grant) begin
            if (winner == OWN_IF) begin
                wait_cnt <= '0;
            end else if (wait_cnt != MAX_W) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the sram_ctrl CPU port between the instruction-fetch and data ports.
// One request in flight at a time; the response is steered back to the owner
// with a one-cycle ack, or an ack plus err if sram_ctrl never answers.
//
// state    | meaning
// ---------+----------------------------------------------------------------
// ST_IDLE  | arbitrate; on a grant latch address/data/owner into mem_* regs
// ST_ISSUE | mem_re or mem_we high for exactly this cycle
// ST_WAIT  | strobes low, waiting for mem_ready or the timeout
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int AW       = AW_DEF,
    parameter int DW       = DW_DEF,
    parameter int MAX_WAIT = 4,
    parameter int TIMEOUT  = 15
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ack,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ack,
    output logic          err,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    output logic          mem_re,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready
);

    // tmo_cnt holds the index of the current WAIT cycle, so comparing against
    // TIMEOUT-1 gives exactly TIMEOUT WAIT cycles before the error completion.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    arb_state_t state_q, state_d;
    owner_t     owner_q;
    owner_t     winner;
    logic       grant;
    logic       done;
    logic       tmo_hit;
    logic       we_q;
    logic [7:0] tmo_cnt;

    arb_prio_starve #(
        .MAX_WAIT (MAX_WAIT)
    ) u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .arb_en (state_q == ST_IDLE),
        .if_req (if_req),
        .d_req  (d_req),
        .grant  (grant),
        .winner (winner)
    );

    // Next-state decode; mem_ready wins over a timeout landing in the same cycle.
    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        tmo_hit = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_ready) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end else if (tmo_cnt == TMO_LAST) begin
                    done    = 1'b1;
                    tmo_hit = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request latch and one-cycle strobe, loaded on the grant edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q   <= OWN_NONE;
            mem_addr  <= '0;
            mem_wdata <= '0;
            we_q      <= 1'b0;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
        end else begin
            mem_re <= 1'b0;
            mem_we <= 1'b0;
            if (grant) begin
                owner_q <= winner;
                if (winner == OWN_IF) begin
                    mem_addr  <= if_addr;
                    mem_wdata <= '0;
                    we_q      <= 1'b0;
                    mem_re    <= 1'b1;
                end else begin
                    mem_addr  <= d_addr;
                    mem_wdata <= d_wdata;
                    we_q      <= d_we;
                    mem_re    <= !d_we;
                    mem_we    <= d_we;
                end
            end else if (done) begin
                owner_q <= OWN_NONE;
            end
        end
    end

    // Timeout counter: cleared while issuing, counts WAIT cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (state_q == ST_ISSUE) begin
            tmo_cnt <= '0;
        end else if (state_q == ST_WAIT) begin
            tmo_cnt <= tmo_cnt + 8'd1;
        end
    end

    // Response steering: ack/err pulse for one cycle, rdata held between acks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_ack   <= 1'b0;
            d_ack    <= 1'b0;
            err      <= 1'b0;
            if_rdata <= '0;
            d_rdata  <= '0;
        end else begin
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            err    <= 1'b0;
            if (done) begin
                err <= tmo_hit;
                if (owner_q == OWN_IF) begin
                    if_ack   <= 1'b1;
                    if_rdata <= tmo_hit ? '0 : mem_rdata;
                end else if (owner_q == OWN_D) begin
                    d_ack   <= 1'b1;
                    d_rdata <= (tmo_hit || we_q) ? '0 : mem_rdata;
                end
            end
        end
    end

endmodule
